// File: rtl/dog_window_gen_pkg.sv
// Shared constants and helpers for the 5x5 DoG window generator.
package dog_window_gen_pkg;

   localparam int PIX_W    = 8;
   localparam int WIN      = 5;
   localparam int LB_COUNT = WIN - 1;

   typedef logic [PIX_W-1:0] pix_t;

   // Counter/address width for a range of n values; never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dog_window_gen_line_buffer.sv
// One image line of pixel storage with same-cycle read and read-before-write.
module line_buffer
   import dog_window_gen_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   localparam int AW   = cntWidth(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Combinational read returns the old word while the same address is written at the edge.
   assign dout = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

endmodule

// File: rtl/dog_window_gen.sv
// Raster-scan 5x5 window builder: four chained line buffers feeding a 5x5 shift array.
module dog_window_gen
   import dog_window_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output logic [PIX_W-1:0] ImageReg1_1,
   output logic [PIX_W-1:0] ImageReg1_2,
   output logic [PIX_W-1:0] ImageReg1_3,
   output logic [PIX_W-1:0] ImageReg1_4,
   output logic [PIX_W-1:0] ImageReg1_5,
   output logic [PIX_W-1:0] ImageReg2_1,
   output logic [PIX_W-1:0] ImageReg2_2,
   output logic [PIX_W-1:0] ImageReg2_3,
   output logic [PIX_W-1:0] ImageReg2_4,
   output logic [PIX_W-1:0] ImageReg2_5,
   output logic [PIX_W-1:0] ImageReg3_1,
   output logic [PIX_W-1:0] ImageReg3_2,
   output logic [PIX_W-1:0] ImageReg3_3,
   output logic [PIX_W-1:0] ImageReg3_4,
   output logic [PIX_W-1:0] ImageReg3_5,
   output logic [PIX_W-1:0] ImageReg4_1,
   output logic [PIX_W-1:0] ImageReg4_2,
   output logic [PIX_W-1:0] ImageReg4_3,
   output logic [PIX_W-1:0] ImageReg4_4,
   output logic [PIX_W-1:0] ImageReg4_5,
   output logic [PIX_W-1:0] ImageReg5_1,
   output logic [PIX_W-1:0] ImageReg5_2,
   output logic [PIX_W-1:0] ImageReg5_3,
   output logic [PIX_W-1:0] ImageReg5_4,
   output logic [PIX_W-1:0] ImageReg5_5,
   output logic             win_valid,
   output logic             frame_done
);

   localparam int CW = cntWidth(IMG_WIDTH);
   localparam int RW = cntWidth(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);

   logic [CW-1:0] colReg, colNext, accCol;
   logic [RW-1:0] rowReg, rowNext, accRow;
   logic          accept;

   pix_t lbIn      [LB_COUNT];
   pix_t lbOut     [LB_COUNT];
   pix_t newCol    [WIN];
   pix_t windowReg [WIN][WIN];
   pix_t windowNext[WIN][WIN];

   assign accept = pix_valid & ~rst;

   // sof relabels the pixel being accepted as (0,0); counters then describe the pixel after it.
   always_comb begin
      accCol  = sof ? '0 : colReg;
      accRow  = sof ? '0 : rowReg;
      colNext = colReg;
      rowNext = rowReg;
      if (pix_valid) begin
         if (accCol == COL_LAST) begin
            colNext = '0;
            rowNext = (accRow == ROW_LAST) ? '0 : accRow + RW'(1);
         end else begin
            colNext = accCol + CW'(1);
            rowNext = accRow;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         colReg <= '0;
         rowReg <= '0;
      end else begin
         colReg <= colNext;
         rowReg <= rowNext;
      end
   end

   // LB1 takes the live pixel; each later buffer takes what the previous one held one line ago.
   generate
      for (genvar gi = 0; gi < LB_COUNT; gi++) begin : gLineBuf
         if (gi == 0) begin : gHead
            assign lbIn[gi] = pix_in;
         end else begin : gChain
            assign lbIn[gi] = lbOut[gi-1];
         end

         line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (PIX_W)
         ) uLineBuf (
            .clk  (clk),
            .we   (accept),
            .addr (accCol),
            .din  (lbIn[gi]),
            .dout (lbOut[gi])
         );

         // Window row 0 is the oldest line, so it is fed by the last buffer in the chain.
         assign newCol[gi] = lbOut[LB_COUNT-1-gi];
      end
   endgenerate

   assign newCol[WIN-1] = pix_in;

   generate
      for (genvar gi = 0; gi < WIN; gi++) begin : gWinRow
         for (genvar gj = 0; gj < WIN; gj++) begin : gWinCol
            if (gj < WIN - 1) begin : gShift
               assign windowNext[gi][gj] = windowReg[gi][gj+1];
            end else begin : gLoad
               assign windowNext[gi][gj] = newCol[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
               windowReg[r][c] <= '0;
            end
         end
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (accept) begin
            windowReg <= windowNext;
         end
         win_valid  <= accept && (accRow >= ROW_FIRST) && (accCol >= COL_FIRST);
         frame_done <= accept && (accRow == ROW_LAST) && (accCol == COL_LAST);
      end
   end

   assign ImageReg1_1 = windowReg[0][0];
   assign ImageReg1_2 = windowReg[0][1];
   assign ImageReg1_3 = windowReg[0][2];
   assign ImageReg1_4 = windowReg[0][3];
   assign ImageReg1_5 = windowReg[0][4];
   assign ImageReg2_1 = windowReg[1][0];
   assign ImageReg2_2 = windowReg[1][1];
   assign ImageReg2_3 = windowReg[1][2];
   assign ImageReg2_4 = windowReg[1][3];
   assign ImageReg2_5 = windowReg[1][4];
   assign ImageReg3_1 = windowReg[2][0];
   assign ImageReg3_2 = windowReg[2][1];
   assign ImageReg3_3 = windowReg[2][2];
   assign ImageReg3_4 = windowReg[2][3];
   assign ImageReg3_5 = windowReg[2][4];
   assign ImageReg4_1 = windowReg[3][0];
   assign ImageReg4_2 = windowReg[3][1];
   assign ImageReg4_3 = windowReg[3][2];
   assign ImageReg4_4 = windowReg[3][3];
   assign ImageReg4_5 = windowReg[3][4];
   assign ImageReg5_1 = windowReg[4][0];
   assign ImageReg5_2 = windowReg[4][1];
   assign ImageReg5_3 = windowReg[4][2];
   assign ImageReg5_4 = windowReg[4][3];
   assign ImageReg5_5 = windowReg[4][4];

endmodule

// File: tb/tb_dog_window_gen.sv
// Directed bench for dog_window_gen on an 8x6 image with pixel = row*16 + col.
module tb_dog_window_gen;

   localparam int W = 8;
   localparam int H = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pix_valid = 1'b0;
   logic       sof = 1'b0;
   logic [7:0] pix_in = 8'h00;
   logic [7:0] win [1:5][1:5];
   logic       win_valid;
   logic       frame_done;

   int total = 0;
   int bad = 0;
   int nValid, nDone;
   int lastR, lastC;
   bit lastValid = 1'b0;

   dog_window_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_in      (pix_in),
      .pix_valid   (pix_valid),
      .sof         (sof),
      .ImageReg1_1 (win[1][1]), .ImageReg1_2 (win[1][2]), .ImageReg1_3 (win[1][3]),
      .ImageReg1_4 (win[1][4]), .ImageReg1_5 (win[1][5]),
      .ImageReg2_1 (win[2][1]), .ImageReg2_2 (win[2][2]), .ImageReg2_3 (win[2][3]),
      .ImageReg2_4 (win[2][4]), .ImageReg2_5 (win[2][5]),
      .ImageReg3_1 (win[3][1]), .ImageReg3_2 (win[3][2]), .ImageReg3_3 (win[3][3]),
      .ImageReg3_4 (win[3][4]), .ImageReg3_5 (win[3][5]),
      .ImageReg4_1 (win[4][1]), .ImageReg4_2 (win[4][2]), .ImageReg4_3 (win[4][3]),
      .ImageReg4_4 (win[4][4]), .ImageReg4_5 (win[4][5]),
      .ImageReg5_1 (win[5][1]), .ImageReg5_2 (win[5][2]), .ImageReg5_3 (win[5][3]),
      .ImageReg5_4 (win[5][4]), .ImageReg5_5 (win[5][5]),
      .win_valid   (win_valid),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Window registered after accepting (r,c): register R_C holds pixel (r-5+R, c-5+C).
   task automatic checkWindow(input string tag, input int r, input int c);
      for (int rr = 1; rr <= 5; rr++) begin
         for (int cc = 1; cc <= 5; cc++) begin
            checkVal($sformatf("%s_w%0d_%0d", tag, rr, cc), int'(win[rr][cc]),
                     (r - 5 + rr) * 16 + (c - 5 + cc));
         end
      end
   endtask

   task automatic checkZeroWindow(input string tag);
      for (int rr = 1; rr <= 5; rr++) begin
         for (int cc = 1; cc <= 5; cc++) begin
            checkVal($sformatf("%s_w%0d_%0d", tag, rr, cc), int'(win[rr][cc]), 0);
         end
      end
      checkVal({tag, "_wv"}, int'(win_valid), 0);
      checkVal({tag, "_fd"}, int'(frame_done), 0);
   endtask

   task automatic sendPix(input int r, input int c, input bit s, input string tag);
      int expV, expD;
      pix_in    = 8'(r * 16 + c);
      pix_valid = 1'b1;
      sof       = s;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      expV = (r >= 4 && c >= 4) ? 1 : 0;
      expD = (r == H - 1 && c == W - 1) ? 1 : 0;
      checkVal($sformatf("%s_wv_%0d_%0d", tag, r, c), int'(win_valid), expV);
      checkVal($sformatf("%s_fd_%0d_%0d", tag, r, c), int'(frame_done), expD);
      if (win_valid) nValid++;
      if (frame_done) nDone++;
      lastValid = (expV != 0);
      lastR = r;
      lastC = c;
      if (expV != 0) checkWindow($sformatf("%s_%0d_%0d", tag, r, c), r, c);
      $display("%s pix (%0d,%0d) sof=%0b wv=%0b fd=%0b", tag, r, c, s, win_valid, frame_done);
   endtask

   // Idle cycles with junk pixel and a possibly-set sof that must be ignored.
   task automatic stallGap(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b0;
         sof       = 1'($urandom_range(0, 1));
         pix_in    = 8'($urandom_range(0, 255));
         @(posedge clk);
         #1;
         checkVal({tag, "_gap_wv"}, int'(win_valid), 0);
         checkVal({tag, "_gap_fd"}, int'(frame_done), 0);
         if (lastValid) checkWindow($sformatf("%s_hold_%0d_%0d", tag, lastR, lastC), lastR, lastC);
      end
      sof = 1'b0;
   endtask

   task automatic sendFrame(input int endR, input int endC, input bit firstSof,
                            input bit stall, input string tag);
      nValid = 0;
      nDone  = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r * W + c <= endR * W + endC) begin
               sendPix(r, c, firstSof && r == 0 && c == 0, tag);
               if (stall && $urandom_range(0, 2) == 0) stallGap(int'($urandom_range(1, 3)), tag);
            end
         end
      end
   endtask

   initial begin
      // Reset held with pix_valid high: nothing may be accepted.
      rst       = 1'b1;
      pix_valid = 1'b1;
      pix_in    = 8'hAB;
      repeat (3) @(posedge clk);
      #1;
      checkZeroWindow("reset");
      rst       = 1'b0;
      pix_valid = 1'b0;

      sendFrame(H - 1, W - 1, 1'b0, 1'b0, "frmA");
      checkVal("frmA_nvalid", nValid, 8);
      checkVal("frmA_ndone", nDone, 1);

      sendFrame(H - 1, W - 1, 1'b1, 1'b1, "frmB");
      checkVal("frmB_nvalid", nValid, 8);
      checkVal("frmB_ndone", nDone, 1);

      sendFrame(3, 2, 1'b0, 1'b0, "partR");
      checkVal("partR_nvalid", nValid, 0);
      checkVal("partR_ndone", nDone, 0);
      rst       = 1'b1;
      pix_valid = 1'b1;
      pix_in    = 8'h77;
      repeat (2) @(posedge clk);
      #1;
      checkZeroWindow("rstMid");
      rst       = 1'b0;
      pix_valid = 1'b0;
      lastValid = 1'b0;
      sendFrame(H - 1, W - 1, 1'b0, 1'b0, "frmC");
      checkVal("frmC_nvalid", nValid, 8);
      checkVal("frmC_ndone", nDone, 1);

      sendFrame(4, 6, 1'b0, 1'b0, "partS");
      checkVal("partS_nvalid", nValid, 3);
      checkVal("partS_ndone", nDone, 0);
      sendFrame(H - 1, W - 1, 1'b1, 1'b0, "frmD");
      checkVal("frmD_nvalid", nValid, 8);
      checkVal("frmD_ndone", nDone, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dog_window_gen.md
# dog_window_gen

Builds the 5x5 pixel neighbourhood consumed by the DoG sum stage from a raster-scan 8-bit pixel stream. It buffers four full image lines and shifts a 5x5 register window one column per accepted pixel. It drives the 25 window registers plus a valid strobe that qualifies windows lying fully inside the image. It sits between the pixel source and the DoG arithmetic, one instance per scale.

## Interface
- IMG_WIDTH, 640, pixels per line (>= 5)
- IMG_HEIGHT, 480, lines per frame (>= 5)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  8  incoming pixel, raster order
- pix_valid  in  1  pix_in is accepted this cycle
- sof  in  1  qualified by pix_valid; marks the accepted pixel as (row 0, col 0)
- ImageRegR_C  out  8 each (R, C = 1..5)  window registers; row 1 oldest line, column 1 oldest pixel
- win_valid  out  1  one-cycle strobe: window is complete and inside the image
- frame_done  out  1  one-cycle strobe after the last pixel of a frame is accepted

## Operation
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) hold the position of the next pixel to be accepted.
  - On accept, col increments.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At the last pixel (H-1, W-1), both wrap to 0.
- sof with pix_valid forces the accepted pixel to position (0,0), and the counters then move to (0,1). sof without pix_valid is ignored.
- Four line buffers LB1..LB4, each IMG_WIDTH x 8, chained.
  - On accept, each buffer is read at address col (read-before-write).
  - LB1 is written with pix_in; LBk is written with the LB(k-1) read data.
  - LBk read data is therefore the pixel k lines above at the same column.
- Window shift on accept, every row R:
  - ImageRegR_C <= ImageRegR_(C+1) for C = 1..4.
  - New column: ImageReg5_5 <= pix_in, ImageReg4_5 <= LB1, ImageReg3_5 <= LB2, ImageReg2_5 <= LB3, ImageReg1_5 <= LB4.
- win_valid <= accept and row >= 4 and col >= 4, evaluated at the accepted pixel's position. The window centre ImageReg3_3 is then pixel (row-2, col-2).
- frame_done <= accept and the accepted position is (IMG_HEIGHT-1, IMG_WIDTH-1).
- With no accept, all window registers, counters and buffers hold. win_valid and frame_done are 0.
- Line-buffer contents are not cleared by reset. Stale data never appears under win_valid because of the row/col gating.
- Windows straddling a line wrap (col < 4) contain previous-line columns and are never flagged valid.

## Timing
- Reset values: all ImageRegR_C = 0, win_valid = 0, frame_done = 0, row = col = 0.
- Latency is 1 cycle: the window update, win_valid and frame_done are registered and visible the cycle after the accepting edge.
- Throughput is one pixel per cycle with no back-pressure. pix_valid may toggle arbitrarily.
- Line-buffer reads are same-cycle (distributed RAM / register array), so one-cycle latency holds. A registered-RAM implementation must add a compensating column delay and keep the external latency identical.
- Reset mid-frame: the next accepted pixel is (0,0). No win_valid until (4,4) of the new frame.
- sof mid-frame behaves the same as reset mid-frame, except that the window registers keep their contents.
- Valid windows per frame = (IMG_WIDTH-4) x (IMG_HEIGHT-4).

## Structure
- Shared package: PIX_W = 8, WIN = 5, and the derived counter widths $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).
- Sub-module line_buffer (params DEPTH, WIDTH): ports clk, we, addr, din, dout, with read-before-write. Instantiated four times in a chain.
- Top level holds the counters, the 5x5 shift array, and the valid/done logic.

## Test plan
Simulation uses IMG_WIDTH = 8, IMG_HEIGHT = 6, and pixel value = row*16 + col.
- Reset:
  - Stimulus: hold rst for 3 cycles with pix_valid high.
  - Required: all ImageRegR_C = 0, win_valid = 0, frame_done = 0; no counter advance.
- First valid window:
  - Stimulus: stream a continuous frame.
  - Required: the first win_valid appears the cycle after accepting (4,4), with ImageReg1_1 = 0x00, ImageReg3_3 = 0x22, ImageReg5_5 = 0x44, ImageReg1_5 = 0x04.
- Per-frame counts:
  - Stimulus: run the full frame.
  - Required: exactly 8 win_valid pulses, and one frame_done the cycle after accepting (5,7).
- Stalls:
  - Stimulus: the same frame with random pix_valid gaps.
  - Required: the window/win_valid sequence is identical to the unstalled run, and outputs hold during gaps.
- Line wrap:
  - Stimulus: accept (5,0)..(5,3).
  - Required: no win_valid during those pixels; at (5,4), ImageReg1_1 = 0x10 and ImageReg5_5 = 0x54.
- Resynchronisation:
  - Stimulus: assert rst after pixel (3,2), then start a new frame; separately, assert sof with pix_valid mid-frame.
  - Required: counting restarts at (0,0) in both cases; first win_valid after the new (4,4); frame_done only at the new frame's end.
